// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one memory bus between the
// instruction (i) and data (d) caches. Requests are whole-line fills or
// write-backs. An address beat is followed, for write-backs, by
// 1<<LOGLINEWORDS data beats. Fill responses are routed back by tag bit 11.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   {i,d}_req_valid/addr/write, {i,d}_wdata       requester inputs
//   {i,d}_req_ready, {i,d}_wdata_ready            accept pulses
//   {i,d}_resp_valid/data/last                    fill beats, no backpressure
//   bus_reqcyc/req/reqtag, bus_reqack             bus request side
//   bus_respcyc/resp/resptag, bus_respack         bus response side
//   tag_err                  sticky: response arrived with no fill pending

// Per-source fill tracker: pending flag plus response beat counter.
module cache_mem_arbiter_lane #(
  parameter int LOGLINEWORDS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic beat,     // response beat addressed to this source
  input  logic set,      // fill address beat accepted for this source
  output logic pending,
  output logic valid,
  output logic last,
  output logic stray
);
  logic [LOGLINEWORDS-1:0] cnt;

  assign valid = beat & pending;
  assign last  = valid & (cnt == '1);
  assign stray = beat & ~pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      if (valid) cnt <= cnt + 1'b1;  // wraps to 0 after the last beat
      if (last)  pending <= 1'b0;
      if (set)   pending <= 1'b1;
    end
  end
endmodule

module cache_mem_arbiter #(
  parameter int LOGLINEWORDS = 3,
  parameter int TAGWIDTH     = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  input  logic [63:0]         i_req_addr,
  input  logic                i_req_write,
  input  logic [63:0]         i_wdata,
  output logic                i_req_ready,
  output logic                i_wdata_ready,
  output logic                i_resp_valid,
  output logic [63:0]         i_resp_data,
  output logic                i_resp_last,
  input  logic                d_req_valid,
  input  logic [63:0]         d_req_addr,
  input  logic                d_req_write,
  input  logic [63:0]         d_wdata,
  output logic                d_req_ready,
  output logic                d_wdata_ready,
  output logic                d_resp_valid,
  output logic [63:0]         d_resp_data,
  output logic                d_resp_last,
  output logic                bus_reqcyc,
  output logic [63:0]         bus_req,
  output logic [TAGWIDTH-1:0] bus_reqtag,
  input  logic                bus_reqack,
  input  logic                bus_respcyc,
  input  logic [63:0]         bus_resp,
  input  logic [TAGWIDTH-1:0] bus_resptag,
  output logic                bus_respack,
  output logic                tag_err
);
  localparam int OFF     = LOGLINEWORDS + 3;  // byte offset bits within a line
  localparam int WR_BIT  = 12;
  localparam int SRC_BIT = 11;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA} state_t;
  state_t state, nxt;

  // Source index: 0 = data, 1 = instruction (matches tag bit 11).
  logic                    src, wr, ptr;
  logic [63:OFF]           line;
  logic [LOGLINEWORDS-1:0] wcnt;
  logic [1:0]              pend, rv, rl, stray, set_pend;
  logic                    elig_d, elig_i, gnt_go, gnt_src;
  logic                    ack_addr, ack_data;
  logic [TAGWIDTH-1:0]     req_tag;
  logic                    unused_ok;

  // ---- response path ----
  genvar k;
  for (k = 0; k < 2; k++) begin : g_lane
    logic hit;
    assign hit = (k == 1) ? bus_resptag[SRC_BIT] : ~bus_resptag[SRC_BIT];
    cache_mem_arbiter_lane #(.LOGLINEWORDS(LOGLINEWORDS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .beat    (bus_respcyc & hit),
      .set     (set_pend[k]),
      .pending (pend[k]),
      .valid   (rv[k]),
      .last    (rl[k]),
      .stray   (stray[k])
    );
  end

  assign bus_respack  = bus_respcyc;
  assign d_resp_valid = rv[0];
  assign d_resp_last  = rl[0];
  assign d_resp_data  = rv[0] ? bus_resp : '0;
  assign i_resp_valid = rv[1];
  assign i_resp_last  = rl[1];
  assign i_resp_data  = rv[1] ? bus_resp : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          tag_err <= 1'b0;
    else if (|stray)    tag_err <= 1'b1;
  end

  // ---- arbitration ----
  // A fill whose previous line finishes this cycle is already eligible:
  // the clear (rl) is folded in before the pending check.
  assign elig_d  = d_req_valid & (d_req_write | ~(pend[0] & ~rl[0]));
  assign elig_i  = i_req_valid & (i_req_write | ~(pend[1] & ~rl[1]));
  assign gnt_go  = elig_d | elig_i;
  assign gnt_src = (elig_d & elig_i) ? ptr : elig_i;

  assign set_pend[0] = ack_addr & ~wr & ~src;
  assign set_pend[1] = ack_addr & ~wr &  src;

  assign d_req_ready   = ack_addr & ~src;
  assign i_req_ready   = ack_addr &  src;
  assign d_wdata_ready = ack_data & ~src;
  assign i_wdata_ready = ack_data &  src;

  always_comb begin
    req_tag          = '0;
    req_tag[WR_BIT]  = wr;
    req_tag[SRC_BIT] = src;
  end

  // ---- request FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    ack_addr   = 1'b0;
    ack_data   = 1'b0;
    case (state)
      IDLE: if (gnt_go) nxt = ADDR;
      ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = {line, {OFF{1'b0}}};
        bus_reqtag = req_tag;
        if (bus_reqack) begin
          ack_addr = 1'b1;
          nxt      = wr ? WDATA : IDLE;
        end
      end
      WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = src ? i_wdata : d_wdata;
        bus_reqtag = req_tag;
        if (bus_reqack) begin
          ack_data = 1'b1;
          if (wcnt == '1) nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Grant latch and write beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src  <= 1'b0;
      wr   <= 1'b0;
      ptr  <= 1'b0;
      line <= '0;
      wcnt <= '0;
    end else if (state == IDLE && gnt_go) begin
      src  <= gnt_src;
      wr   <= gnt_src ? i_req_write : d_req_write;
      line <= gnt_src ? i_req_addr[63:OFF] : d_req_addr[63:OFF];
      ptr  <= ~gnt_src;
      wcnt <= '0;
    end else if (ack_data) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign unused_ok = ^{i_req_addr[OFF-1:0], d_req_addr[OFF-1:0], bus_resptag};
endmodule
